// File: rtl/cr_iu_ibus_pkg.sv
// Shared constants for the IU instruction-bus arbiter: source encoding,
// default sizing and a pointer-width helper.
package cr_iu_ibus_pkg;

   localparam logic SRC_IFU = 1'b0;
   localparam logic SRC_VEC = 1'b1;

   localparam int unsigned DEPTH_DEF = 2;
   localparam int unsigned AW_DEF    = 30;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/cr_iu_ibus_owner_fifo.sv
// Owner FIFO: remembers which requester issued each granted bus transaction
// so responses can be routed back in order.
module cr_iu_ibus_owner_fifo
   import cr_iu_ibus_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CW    = clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          push_src_i,
   input  logic          pop_i,
   output logic          head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

   logic [DEPTH-1:0] mem_q;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_eff, pop_eff;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign pop_eff  = pop_i && !empty_o;
   assign push_eff = push_i && (!full_o || pop_eff);

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_eff) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop_eff)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      if (push_eff && !pop_eff)      count_d = count_q + CW'(1);
      else if (!push_eff && pop_eff) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_eff) mem_q[wr_ptr_q] <= push_src_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cr_iu_ibus_arb.sv
// Instruction-bus arbiter between the vector-table fetch path (fixed priority)
// and the IFU, with request locking and in-order response routing.
module cr_iu_ibus_arb
   import cr_iu_ibus_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic          misc_clk,
   input  logic          cpurst,
   input  logic          vec_req,
   input  logic [AW-1:0] vec_addr,
   output logic          vec_grnt,
   output logic          vec_data_vld,
   output logic          vec_acc_err,
   input  logic          ifu_req,
   input  logic [AW-1:0] ifu_addr,
   output logic          ifu_grnt,
   output logic          ifu_data_vld,
   output logic          ifu_acc_err,
   input  logic          ifu_fetch_mask,
   output logic          arb_ibus_req,
   output logic [AW-1:0] arb_ibus_addr,
   output logic          arb_ibus_src,
   input  logic          bmu_xx_ibus_grnt,
   input  logic          bmu_xx_ibus_data_vld,
   input  logic          bmu_xx_ibus_acc_err,
   output logic          arb_ibus_idle,
   output logic          arb_resp_unexp
);

   localparam int unsigned CW = clog2(DEPTH + 1);

   logic          lock_vld_q, lock_vld_d;
   logic          lock_src_q, lock_src_d;
   logic [AW-1:0] lock_addr_q, lock_addr_d;
   logic          unexp_q, unexp_d;

   logic          fifo_full, fifo_empty, fifo_head;
   logic [CW-1:0] fifo_count;
   logic          vec_elig, ifu_elig, push, resp, route;

   assign vec_elig = vec_req && !fifo_full;
   assign ifu_elig = ifu_req && !ifu_fetch_mask && !fifo_full;

   // A locked request keeps its source and address until granted.
   always_comb begin
      arb_ibus_req  = 1'b0;
      arb_ibus_src  = SRC_IFU;
      arb_ibus_addr = '0;
      if (lock_vld_q) begin
         arb_ibus_req  = 1'b1;
         arb_ibus_src  = lock_src_q;
         arb_ibus_addr = lock_addr_q;
      end else if (vec_elig) begin
         arb_ibus_req  = 1'b1;
         arb_ibus_src  = SRC_VEC;
         arb_ibus_addr = vec_addr;
      end else if (ifu_elig) begin
         arb_ibus_req  = 1'b1;
         arb_ibus_src  = SRC_IFU;
         arb_ibus_addr = ifu_addr;
      end
   end

   assign push     = bmu_xx_ibus_grnt && arb_ibus_req;
   assign vec_grnt = push && (arb_ibus_src == SRC_VEC);
   assign ifu_grnt = push && (arb_ibus_src == SRC_IFU);

   // Access error wins when both response flags are set.
   assign resp  = bmu_xx_ibus_data_vld || bmu_xx_ibus_acc_err;
   assign route = resp && !fifo_empty;

   assign vec_acc_err  = route && bmu_xx_ibus_acc_err && (fifo_head == SRC_VEC);
   assign ifu_acc_err  = route && bmu_xx_ibus_acc_err && (fifo_head == SRC_IFU);
   assign vec_data_vld = route && !bmu_xx_ibus_acc_err && (fifo_head == SRC_VEC);
   assign ifu_data_vld = route && !bmu_xx_ibus_acc_err && (fifo_head == SRC_IFU);

   assign arb_ibus_idle  = (fifo_count == '0) && !lock_vld_q;
   assign arb_resp_unexp = unexp_q;

   always_comb begin
      lock_vld_d  = arb_ibus_req && !bmu_xx_ibus_grnt;
      lock_src_d  = lock_src_q;
      lock_addr_d = lock_addr_q;
      unexp_d     = resp && fifo_empty;
      if (lock_vld_d) begin
         lock_src_d  = arb_ibus_src;
         lock_addr_d = arb_ibus_addr;
      end
   end

   always_ff @(posedge misc_clk) begin
      if (cpurst) begin
         lock_vld_q  <= 1'b0;
         lock_src_q  <= SRC_IFU;
         lock_addr_q <= '0;
         unexp_q     <= 1'b0;
      end else begin
         lock_vld_q  <= lock_vld_d;
         lock_src_q  <= lock_src_d;
         lock_addr_q <= lock_addr_d;
         unexp_q     <= unexp_d;
      end
   end

   cr_iu_ibus_owner_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_owner_fifo (
      .clk_i      (misc_clk),
      .rst_i      (cpurst),
      .push_i     (push),
      .push_src_i (arb_ibus_src),
      .pop_i      (resp),
      .head_o     (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

endmodule
